// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between the ALU result path and data memory.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, is_store      access request from decode (sampled only in IDLE)
//   mem_op[2:0]          RV32I funct3 for the load/store
//   addr[31:0]           effective address
//   wdata[31:0]          store data (rs2)
//   busy                 combinational stall request toward PC/writeback
//   done, err            one-cycle completion pulse and its error flag
//   rdata[31:0]          extended load result, held until the next successful load
//   dm_req, dm_we        data-memory request and write strobe
//   dm_addr, dm_be       word-aligned address and byte enables
//   dm_wdata             lane-replicated store data
//   dm_ack, dm_rdata     memory acknowledge and read word
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                store_q, store_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          lo_q, lo_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                misalign;
  logic                illegal_op;
  logic                fault;
  logic [BE_W-1:0]     be_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W-1:0]   lane;
  logic [DATA_W-1:0]   load_ext;

  // Legality of the presented access: alignment by size plus unsupported funct3 codes
  always_comb begin
    misalign = 1'b0;
    unique case (mem_op[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b0;
    endcase
    if (is_store) begin
      illegal_op = mem_op[2] | (mem_op[1:0] == 2'b11);
    end else begin
      // 011 and 111 via the low bits, 110 via the high bits
      illegal_op = (mem_op[1:0] == 2'b11) | (mem_op[2:1] == 2'b11);
    end
    fault = misalign | illegal_op;
  end

  // Byte enables and lane-replicated write data by access size
  always_comb begin
    be_c    = '0;
    wdata_c = wdata;
    unique case (mem_op[1:0])
      2'b00: begin
        be_c    = BE_W'(4'b0001 << addr[1:0]);
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      2'b10: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
      default: begin
        be_c    = '0;
        wdata_c = wdata;
      end
    endcase
  end

  // Select the addressed lane of the read word and extend per the latched funct3
  always_comb begin
    lane     = dm_rdata >> {lo_q, 3'b000};
    load_ext = lane;
    unique case (op_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    op_d    = op_q;
    lo_d    = lo_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (fault) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_BUS;
            cnt_d   = '0;
            store_d = is_store;
            op_d    = mem_op;
            lo_d    = addr[1:0];
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
          end
        end
      end

      S_BUS: begin
        // An ack in the final wait cycle takes priority over the timeout
        if (dm_ack) begin
          state_d = S_RESP;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          if (!store_q) begin
            rdata_d = load_ext;
          end
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d = S_RESP;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset also drops dm_req mid-access
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      op_q    <= '0;
      lo_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall: whole bus phase, plus the IDLE cycle that launches a legal access
  assign busy = (state_q == S_BUS) | ((state_q == S_IDLE) & start & ~fault);

  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_be    = be_q;
  assign dm_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected completions are queued at start and
// compared when done pulses; bus signals and latency are checked per cycle.
module tb_lsu_ctrl;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, is_store;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_rd = 32'h0;

  lsu_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .is_store(is_store),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check_eq("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_err", 32'(err), 32'(e.err));
        check_eq("sb_rdata", rdata, e.rd);
      end
    end
  end

  // One access: ack_k is the wait-cycle index of the ack (-1 = never)
  task automatic run(input logic st, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_k, input logic [31:0] rd,
                     input logic flt, input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic [31:0] eld);
    exp_t e;
    logic tmo;
    int   k;
    logic fin;
    @(posedge clk); #1;
    start = 1'b1; is_store = st; mem_op = op; addr = a; wdata = wd;
    tmo   = !flt && (ack_k < 0 || ack_k > MAXW - 1);
    e.err = flt || tmo;
    e.rd  = (!flt && !tmo && !st) ? eld : last_rd;
    last_rd = e.rd;
    sb_q.push_back(e);
    @(negedge clk);
    check_eq("busy_start", 32'(busy), 32'(!flt));
    @(posedge clk); #1;
    start = 1'b0;
    if (flt) begin
      @(negedge clk);
      check_eq("flt_done", 32'(done), 32'd1);
      check_eq("flt_noreq", 32'(dm_req), 32'd0);
      check_eq("flt_busy", 32'(busy), 32'd0);
    end else begin
      k   = 0;
      fin = 1'b0;
      while (!fin) begin
        dm_ack   = (k == ack_k);
        dm_rdata = (k == ack_k) ? rd : $urandom;
        @(negedge clk);
        check_eq("bus_req", 32'(dm_req), 32'd1);
        check_eq("bus_we", 32'(dm_we), 32'(st));
        check_eq("bus_addr", dm_addr, {a[31:2], 2'b00});
        check_eq("bus_be", 32'(dm_be), 32'(ebe));
        check_eq("bus_wdata", dm_wdata, ewd);
        check_eq("bus_busy", 32'(busy), 32'd1);
        check_eq("bus_nodone", 32'(done), 32'd0);
        fin = (k == ack_k) || (k == MAXW - 1);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        k++;
      end
      @(negedge clk);
      check_eq("resp_done", 32'(done), 32'd1);
      check_eq("resp_busy", 32'(busy), 32'd0);
      check_eq("resp_noreq", 32'(dm_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; is_store = 1'b0; mem_op = 3'b000;
    addr = 32'h0; wdata = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    #12;
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_req", 32'(dm_req), 32'd0);
    check_eq("rst_we", 32'(dm_we), 32'd0);
    check_eq("rst_addr", dm_addr, 32'h0);
    check_eq("rst_be", 32'(dm_be), 32'd0);
    check_eq("rst_wdata", dm_wdata, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    //  st    op      addr          wdata         ack rd            flt   be       wdata_exp     load_exp
    run(1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    run(1'b0, 3'b000, 32'h0000_0103, 32'h1122_3344, 0, 32'h8012_3456, 1'b0, 4'b1000, 32'h4444_4444, 32'hFFFF_FF80);
    run(1'b0, 3'b100, 32'h0000_0103, 32'h1122_3344, 0, 32'h8012_3456, 1'b0, 4'b1000, 32'h4444_4444, 32'h0000_0080);
    run(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h5555_5555, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    run(1'b0, 3'b001, 32'h0000_0201, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
    run(1'b0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
    run(1'b0, 3'b010, 32'h0000_0300, 32'h0,       -1, 32'h0,        1'b0, 4'b1111, 32'h0,        32'h0);
    run(1'b0, 3'b010, 32'h0000_0304, 32'h0,       14, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0,        32'h0BAD_F00D);
    run(1'b0, 3'b001, 32'h0000_0102, 32'h0,        1, 32'h8001_7FFF, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
    run(1'b0, 3'b101, 32'h0000_0100, 32'h0,        0, 32'h1234_F00D, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D);
    run(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 2, 32'h0,        1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    run(1'b1, 3'b010, 32'h0000_010C, 32'hCAFE_BABE, 1, 32'h0,        1'b0, 4'b1111, 32'hCAFE_BABE, 32'h0);
    run(1'b1, 3'b100, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
    run(1'b1, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
    run(1'b0, 3'b110, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
    run(1'b0, 3'b000, 32'h0000_0102, 32'h0,        0, 32'h0045_0000, 1'b0, 4'b0100, 32'h0,        32'h0000_0045);

    // Reset in the middle of a bus access: request drops at once, no completion
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; mem_op = 3'b010; addr = 32'h0000_0400;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_req", 32'(dm_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_eq("midrst_req", 32'(dm_req), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_rdata", rdata, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    check_eq("post_rst_done", 32'(done), 32'd0);
    run(1'b0, 3'b010, 32'h0000_0500, 32'h0, 2, 32'h1357_9BDF, 1'b0, 4'b1111, 32'h0, 32'h1357_9BDF);

    repeat (3) @(posedge clk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
